tilelink_initiator: RTL

TILELINK_INITIATOR -- requirements
Module: tilelink_initiator

---
 rtl/tilelink_initiator_pkg.sv | 62 ++++++
 rtl/tl_mask_gen.sv | 29 ++
 rtl/tilelink_initiator.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/tilelink_initiator_pkg.sv
// Shared TileLink-UL types for the initiator and any responders: A/D channel
// beats, opcode constants, transfer-size codes and read-data alignment.
package tilelink_initiator_pkg;

    localparam logic [2:0] TL_A_PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] TL_A_GET             = 3'd4;
    localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

    typedef enum logic [1:0] {
        TL_SIZE_BYTE    = 2'd0,
        TL_SIZE_HALF    = 2'd1,
        TL_SIZE_WORD    = 2'd2,
        TL_SIZE_ILLEGAL = 2'd3
    } tl_size_e;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [3:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        a_corrupt;
    } tilelink_a;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [1:0]  d_param;
        logic [1:0]  d_size;
        logic [3:0]  d_source;
        logic        d_sink;
        logic        d_error;
        logic [31:0] d_data;
    } tilelink_d;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } init_state_e;

    // Responders return the whole bus word; move the addressed lanes to bit 0.
    function automatic logic [31:0] tl_read_extract(input logic [31:0] data,
                                                     input logic [1:0]  addr_lo,
                                                     input logic [1:0]  size);
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = data >> {addr_lo, 3'b000};
        case (tl_size_e'(size))
            TL_SIZE_BYTE: result = {24'd0, shifted[7:0]};
            TL_SIZE_HALF: result = {16'd0, shifted[15:0]};
            default:      result = shifted;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/tl_mask_gen.sv
// Byte-lane mask and alignment check for a 32-bit TileLink data bus.
// Illegal size codes are reported as misaligned so callers need one error path.
module tl_mask_gen
    import tilelink_initiator_pkg::*;
(
    input  logic [1:0] size_i,
    input  logic [1:0] addr_lo_i,
    output logic [3:0] mask_o,
    output logic       misalign_o
);

    always_comb begin
        mask_o     = 4'b0000;
        misalign_o = 1'b0;
        case (tl_size_e'(size_i))
            TL_SIZE_BYTE: mask_o = 4'b0001 << addr_lo_i;
            TL_SIZE_HALF: begin
                mask_o     = 4'b0011 << {addr_lo_i[1], 1'b0};
                misalign_o = addr_lo_i[0];
            end
            TL_SIZE_WORD: begin
                mask_o     = 4'b1111;
                misalign_o = |addr_lo_i;
            end
            default: misalign_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/tilelink_initiator.sv
// Single-outstanding TileLink-UL initiator: turns client Get/PutPartialData
// requests into one A beat, waits for the D beat (with timeout), returns a response.
module tilelink_initiator
    import tilelink_initiator_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output tilelink_a   tla,
    input  tilelink_d   tld
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    init_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [1:0]    size_q, size_d;
    logic          write_q, write_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    mask_q, mask_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [3:0] req_mask;
    logic       req_misalign;
    logic [2:0] expected_d_opcode;

    tl_mask_gen u_mask_gen (
        .size_i     (req_size),
        .addr_lo_i  (req_addr[1:0]),
        .mask_o     (req_mask),
        .misalign_o (req_misalign)
    );

    // Routing, ordering and sizing fields of the D beat carry nothing we act on.
    logic unused_tld;
    assign unused_tld = ^{tld.d_param, tld.d_size, tld.d_source, tld.d_sink};

    assign expected_d_opcode = write_q ? TL_D_ACCESS_ACK : TL_D_ACCESS_ACK_DATA;
    assign rsp_rdata         = rdata_q;
    assign rsp_error         = err_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        size_d    = size_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        mask_d    = mask_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        req_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        tla       = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    size_d  = req_size;
                    write_d = req_write;
                    wdata_d = req_wdata;
                    mask_d  = req_mask;
                    // Bad size/alignment never reaches the bus.
                    if (req_misalign) begin
                        state_d = ST_RESP;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                tla.a_valid   = 1'b1;
                tla.a_opcode  = write_q ? TL_A_PUT_PARTIAL : TL_A_GET;
                tla.a_size    = size_q;
                tla.a_address = addr_q;
                tla.a_mask    = mask_q;
                tla.a_data    = wdata_q;
                cnt_d         = '0;
                state_d       = ST_WAIT;
            end
            ST_WAIT: begin
                // A D beat on the final timeout cycle still completes normally.
                if (tld.d_valid) begin
                    state_d = ST_RESP;
                    err_d   = tld.d_error | (tld.d_opcode != expected_d_opcode);
                    rdata_d = write_q ? 32'd0
                                      : tl_read_extract(tld.d_data, addr_q[1:0], size_q);
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            mask_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule
